// File: rtl/mc_controller.sv
// mc_controller: multi-cycle instruction sequencer; every control strobe is registered
// from the next state so outputs are glitch-free and clear asynchronously on reset.
module mc_controller #(
    parameter int ADDR_W   = 11,
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    input  logic       P,
    input  logic       U,
    input  logic       W,
    output logic       load_pc,
    output logic       load_ir,
    output logic       en_A,
    output logic       en_B,
    output logic       en_S,
    output logic       en_C,
    output logic       en_status,
    output logic [1:0] sel_pc,
    output logic       sel_A,
    output logic       sel_B,
    output logic       sel_post_shift,
    output logic       sel_w_data,
    output logic [2:0] ALU_op,
    output logic       w_en1,
    output logic       w_en2,
    output logic       w_en3,
    output logic       ram_w_en,
    output logic       waiting,
    output logic       halted,
    output logic [3:0] state_o
);

    if (MEM_WAIT < 1 || MEM_WAIT > 15 || ADDR_W < 1) begin : g_param_check
        $error("mc_controller: MEM_WAIT must be 1..15 and ADDR_W positive");
    end

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_LOAD_PC    = 4'd1,
        S_FETCH      = 4'd2,
        S_FETCH_WAIT = 4'd3,
        S_DECODE     = 4'd4,
        S_EXECUTE    = 4'd5,
        S_MEMORY     = 4'd6,
        S_MEM_WAIT   = 4'd7,
        S_WRITE_BACK = 4'd8,
        S_HALT       = 4'd9
    } state_t;

    typedef struct packed {
        logic       load_pc, load_ir, en_a, en_b, en_s, en_c, en_status;
        logic [1:0] sel_pc;
        logic       sel_a, sel_b, sel_post_shift;
        logic [2:0] alu_op;
        logic       w_en1, w_en2, w_en3, ram_w_en, halted;
    } ctrl_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011, OP_XOR = 3'b111;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      out_q, out_d;
    logic       is_alu, is_mem, is_str, is_hlt, is_cmp, cond_ok;
    logic [7:0] flag_tab;
    logic [2:0] alu_fn;

    assign is_hlt = opcode == 7'b0000001;
    assign is_alu = ~opcode[6] & (opcode != 7'b0000000) & ~is_hlt;
    assign is_mem = (opcode[6:5] == 2'b11) | (opcode[6:3] == 4'b1000);
    assign is_str = is_mem & opcode[4];
    assign is_cmp = opcode[3:0] == 4'b1010;

    // Each ARM condition pair shares a base test; the odd code is its inverse (AL/NV too).
    assign flag_tab = {1'b1, ~nzcv[2] & (nzcv[3] == nzcv[0]), nzcv[3] == nzcv[0],
                       nzcv[1] & ~nzcv[2], nzcv[0], nzcv[3], nzcv[1], nzcv[2]};
    assign cond_ok  = flag_tab[cond[3:1]] ^ cond[0];

    assign alu_fn = (opcode[2:0] == 3'd1 || opcode[2:0] == 3'd2) ? OP_SUB :
                    opcode[2:0] == 3'd3 ? OP_AND :
                    opcode[2:0] == 3'd4 ? OP_ORR :
                    opcode[2:0] == 3'd5 ? OP_XOR : OP_ADD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET:      state_d = S_LOAD_PC;
            S_LOAD_PC:    state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_FETCH_WAIT;
                cnt_d   = WAIT_LAST;
            end
            S_FETCH_WAIT, S_MEM_WAIT:
                if (cnt_q == 4'd0) state_d = state_q == S_FETCH_WAIT ? S_DECODE : S_WRITE_BACK;
                else cnt_d = cnt_q - 4'd1;
            S_DECODE:     state_d = is_hlt ? S_HALT : ((is_alu | is_mem) & cond_ok) ? S_EXECUTE : S_LOAD_PC;
            S_EXECUTE:    state_d = S_MEMORY;
            S_MEMORY: begin
                state_d = is_mem ? S_MEM_WAIT : S_WRITE_BACK;
                cnt_d   = WAIT_LAST;
            end
            S_WRITE_BACK: state_d = S_LOAD_PC;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_RESET;
        endcase
    end

    // Strobes are computed for the state being entered, so they are valid for its whole cycle.
    always_comb begin
        out_d         = '0;
        out_d.halted  = state_d == S_HALT;
        out_d.load_pc = state_d == S_LOAD_PC;
        out_d.sel_pc  = {1'b0, state_d == S_LOAD_PC};
        out_d.load_ir = state_d == S_FETCH_WAIT && cnt_d == 4'd0;
        if (state_d == S_EXECUTE) begin
            out_d.en_a = is_mem | opcode[3];
            out_d.en_b = is_mem ? opcode[3] : opcode[4];
            out_d.en_s = ~is_mem | opcode[3];
        end
        if (state_d == S_MEMORY) begin
            out_d.en_c           = 1'b1;
            out_d.alu_op         = is_mem ? (U ? OP_ADD : OP_SUB) : alu_fn;
            out_d.sel_a          = ~is_mem & ~opcode[3];
            out_d.sel_b          = ~(is_mem ? opcode[3] : opcode[4]);
            out_d.sel_post_shift = is_mem & ~P;
            out_d.ram_w_en       = is_str;
            out_d.w_en1          = ~is_mem & ~is_cmp;
            out_d.en_status      = ~is_mem & is_cmp;
        end
        if (state_d == S_WRITE_BACK) begin
            out_d.w_en3 = is_mem & ~is_str;
            out_d.w_en2 = is_mem & (W | ~P);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign load_pc        = out_q.load_pc;
    assign load_ir        = out_q.load_ir;
    assign en_A           = out_q.en_a;
    assign en_B           = out_q.en_b;
    assign en_S           = out_q.en_s;
    assign en_C           = out_q.en_c;
    assign en_status      = out_q.en_status;
    assign sel_pc         = out_q.sel_pc;
    assign sel_A          = out_q.sel_a;
    assign sel_B          = out_q.sel_b;
    assign sel_post_shift = out_q.sel_post_shift;
    assign sel_w_data     = 1'b0;
    assign ALU_op         = out_q.alu_op;
    assign w_en1          = out_q.w_en1;
    assign w_en2          = out_q.w_en2;
    assign w_en3          = out_q.w_en3;
    assign ram_w_en       = out_q.ram_w_en;
    assign halted         = out_q.halted;
    assign waiting        = ~out_q.halted;
    assign state_o        = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: two controllers (MEM_WAIT=1 and 3) checked every cycle against a
// state/dwell-count reference model, plus directed per-instruction expectations.
module tb_mc_controller;
    logic       clk = 0, rst_n = 1;
    logic [6:0] opcode = 0;
    logic [3:0] cond = 4'he, nzcv = 0;
    logic       P = 1, U = 1, W = 0;
    bit         go = 0;
    int         total = 0, bad = 0, cyc = 0;
    wire [1:0][25:0] o;

    localparam logic [23:0] AOP = {3'b000, 3'b000, 3'b111, 3'b011, 3'b010, 3'b001, 3'b001, 3'b000};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_controller #(.MEM_WAIT(g == 0 ? 1 : 3)) u (
            .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond(cond), .nzcv(nzcv),
            .P(P), .U(U), .W(W),
            .load_pc(o[g][25]), .load_ir(o[g][24]), .en_A(o[g][23]), .en_B(o[g][22]),
            .en_S(o[g][21]), .en_C(o[g][20]), .en_status(o[g][19]), .sel_pc(o[g][18:17]),
            .sel_A(o[g][16]), .sel_B(o[g][15]), .sel_post_shift(o[g][14]), .sel_w_data(o[g][13]),
            .ALU_op(o[g][12:10]), .w_en1(o[g][9]), .w_en2(o[g][8]), .w_en3(o[g][7]),
            .ram_w_en(o[g][6]), .waiting(o[g][5]), .halted(o[g][4]), .state_o(o[g][3:0])
        );
    end

    function automatic int mwof(int k);
        return k == 0 ? 1 : 3;
    endfunction

    function automatic bit f_mem(logic [6:0] op);
        return op[6:5] == 2'b11 || op[6:3] == 4'b1000;
    endfunction

    function automatic bit f_alu(logic [6:0] op);
        return !op[6] && op > 7'd1;
    endfunction

    function automatic bit f_cond(logic [3:0] c, logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0: return z;
            4'd1: return !z;
            4'd2: return cf;
            4'd3: return !cf;
            4'd4: return n;
            4'd5: return !n;
            4'd6: return v;
            4'd7: return !v;
            4'd8: return cf && !z;
            4'd9: return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && n == v;
            4'd13: return z || n != v;
            4'd14: return 1;
            default: return 0;
        endcase
    endfunction

    // Reference: state number plus 1-based count of cycles spent in a wait state.
    int ms[2], md[2];
    always @(posedge clk or negedge rst_n)
        for (int k = 0; k < 2; k++)
            if (!rst_n) begin
                ms[k] <= 0;
                md[k] <= 0;
            end else
                case (ms[k])
                    2: begin ms[k] <= 3; md[k] <= 1; end
                    3: if (md[k] == mwof(k)) ms[k] <= 4; else md[k] <= md[k] + 1;
                    4: ms[k] <= opcode == 7'd1 ? 9 :
                               ((f_alu(opcode) || f_mem(opcode)) && f_cond(cond, nzcv)) ? 5 : 1;
                    6: if (f_mem(opcode)) begin ms[k] <= 7; md[k] <= 1; end else ms[k] <= 8;
                    7: if (md[k] == mwof(k)) ms[k] <= 8; else md[k] <= md[k] + 1;
                    8: ms[k] <= 1;
                    9: ms[k] <= 9;
                    default: ms[k] <= ms[k] + 1;
                endcase

    function automatic logic [25:0] expect_out(int s, int d, int mw);
        logic [25:0] r;
        bit mem, str;
        mem = f_mem(opcode);
        str = mem && opcode[4];
        r = '0;
        r[5] = s != 9;
        r[4] = s == 9;
        r[3:0] = 4'(s);
        if (s == 1) begin r[25] = 1; r[18:17] = 2'b01; end
        if (s == 3) r[24] = d == mw;
        if (s == 5) begin
            if (mem) begin r[23] = 1; r[22] = opcode[3]; r[21] = opcode[3]; end
            else begin r[23] = opcode[3]; r[22] = opcode[4]; r[21] = 1; end
        end
        if (s == 6) begin
            r[20] = 1;
            if (mem) begin
                r[12:10] = U ? 3'b000 : 3'b001;
                r[15] = !opcode[3];
                r[14] = !P;
                r[6] = str;
            end else begin
                r[12:10] = AOP[opcode[2:0]*3 +: 3];
                r[16] = !opcode[3];
                r[15] = !opcode[4];
                r[9] = opcode[3:0] != 4'b1010;
                r[19] = opcode[3:0] == 4'b1010;
            end
        end
        if (s == 8) begin r[7] = mem && !str; r[8] = mem && (W || !P); end
        return r;
    endfunction

    int lp_seen[2], first_lp[2], len[2], n_w1[2], n_w2[2], n_w3[2], n_rw[2];
    int n_est[2], n_fw[2], n_mw[2], ldir_at[2], n_halt[2], aop[2], spost[2];

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            logic [25:0] obs, ex;
            obs = o[k];
            ex = expect_out(ms[k], md[k], mwof(k));
            if (go) begin
                total++;
                if (obs !== ex) begin
                    bad++;
                    $display("FAIL cycle_compare inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs, ex);
                end
            end
            if (!rst_n) begin
                lp_seen[k] = 0; len[k] = 0; n_w1[k] = 0; n_w2[k] = 0; n_w3[k] = 0; n_rw[k] = 0;
                n_est[k] = 0; n_fw[k] = 0; n_mw[k] = 0; ldir_at[k] = 0; n_halt[k] = 0;
                aop[k] = -1; spost[k] = 0;
            end else begin
                if (obs[3:0] == 4'd1) begin
                    if (lp_seen[k] == 0) begin lp_seen[k] = 1; first_lp[k] = cyc; end
                    else if (lp_seen[k] == 1) begin len[k] = cyc - first_lp[k]; lp_seen[k] = 2; end
                end
                if (lp_seen[k] == 1) begin
                    n_w1[k] += int'(obs[9]);
                    n_w2[k] += int'(obs[8]);
                    n_w3[k] += int'(obs[7]);
                    n_rw[k] += int'(obs[6]);
                    n_est[k] += int'(obs[19]);
                    n_halt[k] += int'(obs[4]);
                    if (obs[3:0] == 4'd3) n_fw[k]++;
                    if (obs[24]) ldir_at[k] = n_fw[k];
                    if (obs[3:0] == 4'd7) n_mw[k]++;
                    if (obs[3:0] == 4'd6) begin aop[k] = int'(obs[12:10]); spost[k] = int'(obs[14]); end
                end
            end
        end
    endtask

    task automatic check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic do_reset(input logic [6:0] op, input logic [3:0] c, input logic [3:0] f,
                            input logic p, input logic u, input logic w);
        tick();
        #2 rst_n = 0;
        opcode = op; cond = c; nzcv = f; P = p; U = u; W = w;
        tick();
        tick();
        #2 rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        #1 rst_n = 0;
        #1 go = 1;
        for (int k = 0; k < 2; k++) begin
            check("reset_outputs", int'(o[k]), 32'h20);
            check("reset_waiting", int'(o[k][5]), 1);
        end
        tick();

        do_reset(7'b0001000, 4'b1110, 4'b0000, 1, 1, 0);
        repeat (22) tick();
        check("add_loop_len_mw1", len[0], 7);
        check("add_w_en1_pulses", n_w1[0], 1);
        check("add_alu_op", aop[0], 0);
        check("add_loop_len_mw3", len[1], 9);

        do_reset(7'b1100000, 4'b1110, 4'b0000, 0, 1, 0);
        repeat (22) tick();
        check("ldr_fetch_wait_cycles", n_fw[1], 3);
        check("ldr_load_ir_position", ldir_at[1], 3);
        check("ldr_mem_wait_cycles", n_mw[1], 3);
        check("ldr_w_en3", n_w3[1], 1);
        check("ldr_w_en2", n_w2[1], 1);
        check("ldr_post_shift", spost[1], 1);
        check("ldr_loop_len", len[1], 12);

        do_reset(7'b0001000, 4'b0000, 4'b0000, 1, 1, 0);
        repeat (12) tick();
        check("eq_fail_len_mw1", len[0], 4);
        check("eq_fail_len_mw3", len[1], 6);
        check("eq_fail_writes", n_w1[0] + n_w2[0] + n_w3[0] + n_rw[0], 0);

        do_reset(7'b0001000, 4'b0000, 4'b0100, 1, 1, 0);
        repeat (12) tick();
        check("eq_pass_len", len[0], 7);

        do_reset(7'b0001000, 4'b1111, 4'b0100, 1, 1, 0);
        repeat (12) tick();
        check("never_len", len[0], 4);

        do_reset(7'b0001010, 4'b1110, 4'b0000, 1, 1, 0);
        repeat (12) tick();
        check("cmp_en_status", n_est[0], 1);
        check("cmp_w_en1", n_w1[0], 0);
        check("cmp_alu_op", aop[0], 1);

        do_reset(7'b0000001, 4'b0000, 4'b0000, 1, 1, 0);
        repeat (30) tick();
        check("hlt_held_mw1", int'(n_halt[0] >= 20), 1);
        check("hlt_held_mw3", int'(n_halt[1] >= 20), 1);
        tick();
        #2 rst_n = 0;
        #1;
        check("hlt_reset_state", int'(o[0][3:0]), 0);
        check("hlt_reset_halted", int'(o[0][4]), 0);
        tick();
        #2 rst_n = 1;

        do_reset(7'b1110000, 4'b1110, 4'b0000, 1, 1, 0);
        t = 0;
        while (o[1][3:0] != 4'd7 && t < 40) begin tick(); t++; end
        check("str_reach_mem_wait", int'(o[1][3:0]), 7);
        check("str_ram_pulse", n_rw[1], 1);
        #2 rst_n = 0;
        #1;
        check("str_reset_outputs", int'(o[1]), 32'h20);
        opcode = 7'b0001000;
        tick();
        tick();
        #2 rst_n = 1;
        repeat (14) tick();
        check("restart_fetch_wait", n_fw[1], 3);
        check("restart_load_ir", ldir_at[1], 3);
        check("restart_loop_len", len[1], 9);
        check("restart_no_store", n_rw[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
